// File: rtl/sensor_scheduler.sv
// Round-robin scheduler for four sensor requesters sharing one UART link engine, with watchdog and retry.
// Define SCHED_AUTOPOLL_EN to autopoll sensor ids 0..POLL_LAST after POLL_INTERVAL idle cycles.
module sensor_scheduler #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRY      = 2,
    parameter int POLL_INTERVAL  = 5000,
    parameter int POLL_LAST      = 31
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [3:0]  req_i,
    input  logic [31:0] req_sensor_i,
    output logic [3:0]  gnt_o,
    output logic [3:0]  resp_valid_o,
    output logic [7:0]  resp_data_o,
    output logic        resp_err_o,
    output logic        poll_valid_o,
    output logic        link_start_o,
    output logic [7:0]  link_sensor_o,
    input  logic        link_busy_i,
    input  logic        link_done_i,
    input  logic        link_ok_i,
    input  logic [7:0]  link_data_i
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    if (TIMEOUT_CYCLES < 1 || MAX_RETRY < 0 || POLL_INTERVAL < 1 || POLL_LAST < 0 || POLL_LAST > 255)
    begin : g_bad_params
        $error("sensor_scheduler: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t        state_q, state_d;
    logic [1:0]    winner_q, winner_d;
    logic [1:0]    last_q, last_d;
    logic [7:0]    sensor_q, sensor_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          poll_active;

    logic [7:0] req_sensor_arr [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_sensor
        assign req_sensor_arr[gi] = req_sensor_i[8*gi +: 8];
    end

`ifdef SCHED_AUTOPOLL_EN
    localparam int IW = $clog2(POLL_INTERVAL + 1);
    logic          poll_q, poll_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [7:0]    poll_id_q, poll_id_d;
    assign poll_active = poll_q;
`else
    assign poll_active = 1'b0;
`endif

    // Round-robin search starting one past the last served requester.
    logic       rr_found;
    logic [1:0] rr_winner;
    logic [1:0] rr_idx;
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_q;
        rr_idx    = last_q;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last_q + 2'(i);
            if (!rr_found && req_i[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        sensor_d = sensor_q;
        data_d   = data_q;
        err_d    = err_q;
        retry_d  = retry_q;
        wdog_d   = wdog_q;
`ifdef SCHED_AUTOPOLL_EN
        poll_d    = poll_q;
        idle_d    = idle_q;
        poll_id_d = poll_id_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef SCHED_AUTOPOLL_EN
                idle_d = idle_q + IW'(1);
`endif
                if (rr_found) begin
                    winner_d = rr_winner;
                    sensor_d = req_sensor_arr[rr_winner];
                    state_d  = ISSUE;
`ifdef SCHED_AUTOPOLL_EN
                    poll_d = 1'b0;
                    idle_d = '0;
                end else if (idle_q == IW'(POLL_INTERVAL - 1)) begin
                    poll_d    = 1'b1;
                    sensor_d  = poll_id_q;
                    poll_id_d = (poll_id_q == 8'(POLL_LAST)) ? 8'h00 : poll_id_q + 8'h01;
                    idle_d    = '0;
                    state_d   = ISSUE;
`endif
                end
            end
            ISSUE: begin
                if (!link_busy_i) begin
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wdog_d = wdog_q + WW'(1);
                // link_done wins over a coincident watchdog expiry.
                if (link_done_i && link_ok_i) begin
                    data_d  = link_data_i;
                    err_d   = 1'b0;
                    state_d = RESPOND;
                end else if (link_done_i || wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ISSUE;
                    end else begin
                        data_d  = 8'h00;
                        err_d   = 1'b1;
                        state_d = RESPOND;
                    end
                end
            end
            RESPOND: begin
                if (!poll_active) begin
                    last_d = winner_q;
                end
                retry_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            winner_q <= 2'd0;
            last_q   <= 2'd3;
            sensor_q <= 8'h00;
            data_q   <= 8'h00;
            err_q    <= 1'b0;
            retry_q  <= '0;
            wdog_q   <= '0;
`ifdef SCHED_AUTOPOLL_EN
            poll_q    <= 1'b0;
            idle_q    <= '0;
            poll_id_q <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            sensor_q <= sensor_d;
            data_q   <= data_d;
            err_q    <= err_d;
            retry_q  <= retry_d;
            wdog_q   <= wdog_d;
`ifdef SCHED_AUTOPOLL_EN
            poll_q    <= poll_d;
            idle_q    <= idle_d;
            poll_id_q <= poll_id_d;
`endif
        end
    end

    assign gnt_o         = (state_q != IDLE && !poll_active) ? (4'b0001 << winner_q) : 4'b0000;
    assign resp_valid_o  = (state_q == RESPOND && !poll_active) ? (4'b0001 << winner_q) : 4'b0000;
    assign poll_valid_o  = (state_q == RESPOND) && poll_active;
    assign link_start_o  = (state_q == ISSUE) && !link_busy_i;
    assign link_sensor_o = sensor_q;
    assign resp_data_o   = data_q;
    assign resp_err_o    = err_q;
endmodule

// File: tb/tb_sensor_scheduler.sv
// Bench for sensor_scheduler: vector table plus hand sequences, with a behavioural link engine
// and a response scoreboard. With SCHED_AUTOPOLL_EN defined only the autopoll sequence runs.
module tb_sensor_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_sensor;
    logic [3:0]  gnt;
    logic [3:0]  resp_valid;
    logic [7:0]  resp_data;
    logic        resp_err;
    logic        poll_valid;
    logic        link_start;
    logic [7:0]  link_sensor;
    logic        link_busy;
    logic        link_done;
    logic        link_ok;
    logic [7:0]  link_data;

    sensor_scheduler #(
        .TIMEOUT_CYCLES(8),
        .MAX_RETRY(2),
        .POLL_INTERVAL(10),
        .POLL_LAST(31)
    ) dut (
        .clock_i(clk),
        .reset_i(reset),
        .req_i(req),
        .req_sensor_i(req_sensor),
        .gnt_o(gnt),
        .resp_valid_o(resp_valid),
        .resp_data_o(resp_data),
        .resp_err_o(resp_err),
        .poll_valid_o(poll_valid),
        .link_start_o(link_start),
        .link_sensor_o(link_sensor),
        .link_busy_i(link_busy),
        .link_done_i(link_done),
        .link_ok_i(link_ok),
        .link_data_i(link_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard of expected response strobes.
    typedef struct {
        logic [3:0] valid;
        logic       poll;
        logic [7:0] data;
        logic       err;
    } exp_t;
    exp_t sb[$];

    // Link engine model: answers each link_start after cfg_delay cycles.
    int   cyc = 0;
    int   start_cyc[$];
    logic cfg_respond = 1'b1;
    logic cfg_ok      = 1'b1;
    logic [7:0] cfg_data = 8'h00;
    int   cfg_delay   = 2;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int cd;
        cd        = 0;
        link_done = 1'b0;
        link_ok   = 1'b0;
        link_data = 8'h00;
        forever begin
            @(negedge clk);
            link_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && cfg_respond) begin
                    link_done = 1'b1;
                    link_ok   = cfg_ok;
                    link_data = cfg_data;
                end
            end
            if (link_start) begin
                start_cyc.push_back(cyc);
                cd = cfg_delay;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid != 4'b0000 || poll_valid) begin
                $display("resp: valid=%b poll=%b data=0x%02h err=%b gnt=%b",
                         resp_valid, poll_valid, resp_data, resp_err, gnt);
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {resp_valid, poll_valid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("resp_valid", resp_valid, e.valid);
                    check("poll_valid", poll_valid, e.poll);
                    check("resp_data", resp_data, e.data);
                    check("resp_err", resp_err, e.err);
                    check("gnt_at_respond", gnt, e.valid);
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] sens;
        logic        ok;
        logic [7:0]  data;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_sensor;
        int          exp_starts;
    } vec_t;
    vec_t tv[7];

    initial begin
        int s0;
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        int s0;
        // Round-robin expectations follow from last_served = 3 after reset.
        tv[0] = '{4'b0001, 32'h0D0C0B05, 1'b1, 8'h2A, 4'b0001, 8'h05, 1};
        tv[1] = '{4'b0011, 32'h44332211, 1'b1, 8'h5A, 4'b0010, 8'h22, 1};
        tv[2] = '{4'b1001, 32'h44332211, 1'b1, 8'h81, 4'b1000, 8'h44, 1};
        tv[3] = '{4'b1001, 32'h44332211, 1'b1, 8'hFF, 4'b0001, 8'h11, 1};
        tv[4] = '{4'b0100, 32'h11002233, 1'b1, 8'h3C, 4'b0100, 8'h00, 1};
        tv[5] = '{4'b1010, 32'h99887766, 1'b1, 8'hC3, 4'b1000, 8'h99, 1};
        tv[6] = '{4'b0110, 32'h44332211, 1'b0, 8'hEE, 4'b0010, 8'h22, 3};

        reset      = 1'b1;
        req        = 4'b0000;
        req_sensor = 32'h0;
        link_busy  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_resp_valid", resp_valid, 4'b0000);
        check("rst_link_start", link_start, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_data", resp_data, 8'h00);
        check("rst_link_sensor", link_sensor, 8'h00);
        check("rst_poll_valid", poll_valid, 1'b0);

`ifdef SCHED_AUTOPOLL_EN
        for (int i = 0; i < 2; i++) begin
            int n;
            cfg_ok   = 1'b1;
            cfg_data = 8'h60 + 8'(i);
            sb.push_back('{4'b0000, 1'b1, 8'h60 + 8'(i), 1'b0});
            n = 0;
            while (!link_start && n < 40) begin
                step();
                n++;
            end
            check("poll_start_seen", link_start, 1'b1);
            check("poll_link_sensor", link_sensor, 32'(i));
            check("poll_gnt", gnt, 4'b0000);
            wait_drain(60);
        end
`else
        for (int v = 0; v < 7; v++) begin
            cfg_respond = 1'b1;
            cfg_ok      = tv[v].ok;
            cfg_data    = tv[v].data;
            cfg_delay   = 2;
            s0          = start_cyc.size();
            req         = tv[v].req;
            req_sensor  = tv[v].sens;
            sb.push_back('{tv[v].exp_gnt, 1'b0, tv[v].ok ? tv[v].data : 8'h00, !tv[v].ok});
            step();
            check($sformatf("v%0d_link_start", v), link_start, 1'b1);
            check($sformatf("v%0d_gnt", v), gnt, tv[v].exp_gnt);
            check($sformatf("v%0d_link_sensor", v), link_sensor, tv[v].exp_sensor);
            req = 4'b0000;
            wait_drain(100);
            step();
            check($sformatf("v%0d_starts", v), start_cyc.size() - s0, tv[v].exp_starts);
        end

        // Watchdog: no link_done at all; re-issue every 8 WAIT cycles, error after three attempts.
        cfg_respond = 1'b0;
        start_cyc.delete();
        req = 4'b0001;
        sb.push_back('{4'b0001, 1'b0, 8'h00, 1'b1});
        step();
        req = 4'b0000;
        wait_drain(100);
        check("to_starts", start_cyc.size(), 3);
        if (start_cyc.size() == 3) begin
            check("to_gap1", start_cyc[1] - start_cyc[0], 9);
            check("to_gap2", start_cyc[2] - start_cyc[1], 9);
        end
        step();

        // link_busy holds ISSUE with link_start low.
        cfg_respond = 1'b1;
        cfg_ok      = 1'b1;
        cfg_data    = 8'h42;
        link_busy   = 1'b1;
        s0          = start_cyc.size();
        req         = 4'b0100;
        sb.push_back('{4'b0100, 1'b0, 8'h42, 1'b0});
        step();
        check("busy_start_low", link_start, 1'b0);
        check("busy_gnt", gnt, 4'b0100);
        req = 4'b0000;
        step();
        check("busy_start_low2", link_start, 1'b0);
        @(posedge clk);
        #1;
        link_busy = 1'b0;
        step();
        check("busy_start_high", link_start, 1'b1);
        wait_drain(100);
        step();
        check("busy_starts", start_cyc.size() - s0, 1);

        // Reset in WAIT: transaction abandoned, later link_done ignored.
        cfg_delay = 6;
        cfg_data  = 8'h99;
        s0        = start_cyc.size();
        req       = 4'b1111 & 4'b0010;
        step();
        check("rstw_gnt", gnt, 4'b0010);
        req = 4'b0000;
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (10) step();
        check("rstw_gnt_idle", gnt, 4'b0000);
        check("rstw_resp_data", resp_data, 8'h00);
        check("rstw_link_sensor", link_sensor, 8'h00);
        check("rstw_starts", start_cyc.size() - s0, 1);

        // All four requesting: order 0,1,2,3 after reset.
        cfg_delay = 2;
        cfg_data  = 8'h77;
        s0        = start_cyc.size();
        sb.push_back('{4'b0001, 1'b0, 8'h77, 1'b0});
        sb.push_back('{4'b0010, 1'b0, 8'h77, 1'b0});
        sb.push_back('{4'b0100, 1'b0, 8'h77, 1'b0});
        sb.push_back('{4'b1000, 1'b0, 8'h77, 1'b0});
        req        = 4'b1111;
        req_sensor = 32'hD3C2B1A0;
        wait_drain(200);
        req = 4'b0000;
        repeat (6) step();
        check("rr_starts", start_cyc.size() - s0, 4);
        check("rr_gnt_idle", gnt, 4'b0000);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
